// File: rtl/einstein_kbd_matrix_if.sv
// Keyboard-side bus of the Einstein keyboard matrix.
//   ps2_key  : MiSTer PS/2 event word {toggle, press, ext, code[7:0]}
//   kb_row   : active-low row select from PSG port A
//   kb_col   : active-low column readback to PSG port B
//   kb_shift, kb_ctrl, kb_graph : active-low modifier lines
//   kb_down  : high while any matrix key is held
// master = event source / PSG side, slave = einstein_kbd_matrix.
interface einstein_kbd_matrix_if;
  logic [10:0] ps2_key;
  logic [7:0]  kb_row;
  logic [7:0]  kb_col;
  logic        kb_shift;
  logic        kb_ctrl;
  logic        kb_graph;
  logic        kb_down;

  modport master (
    output ps2_key, kb_row,
    input  kb_col, kb_shift, kb_ctrl, kb_graph, kb_down
  );

  modport slave (
    input  ps2_key, kb_row,
    output kb_col, kb_shift, kb_ctrl, kb_graph, kb_down
  );
endinterface

// File: rtl/einstein_kbd_matrix.sv
// Einstein keyboard front end: PS/2 key events -> 8x8 key matrix, modifier lines and kb_down.
// Short taps are stretched by a shared hold counter; releases arriving while the hold is
// running are queued in a small FIFO and drained one per cycle once the hold expires.
// Ports:
//   clk_sys : system clock
//   reset   : asynchronous active-high reset
//   kbd     : einstein_kbd_matrix_if.slave (ps2_key, kb_row in; kb_col, modifiers, kb_down out)
module einstein_kbd_matrix #(
  parameter int unsigned MIN_HOLD   = 640000,
  parameter int unsigned HOLD_W     = 20,
  parameter int unsigned RELQ_DEPTH = 4
) (
  input logic                  clk_sys,
  input logic                  reset,
  einstein_kbd_matrix_if.slave kbd
);

  localparam int unsigned PtrW = $clog2(RELQ_DEPTH);
  localparam logic [HOLD_W-1:0] HoldLoad = HOLD_W'(MIN_HOLD);
  localparam logic [PtrW:0] DepthVal = (PtrW + 1)'(RELQ_DEPTH);

  typedef enum logic [2:0] {EvNone, EvMatrix, EvShiftL, EvShiftR, EvCtrl, EvGraph} ev_kind_e;

  // S0 / S1
  logic       strobe_q;
  logic       s1_valid_q;
  logic       s1_press_q;
  logic [8:0] s1_key_q;   // {ext, code}
  // S2
  logic       s2_valid_q;
  logic       s2_press_q;
  ev_kind_e   s2_kind_q;
  logic [5:0] s2_rc_q;    // {row, col}
  // Decode
  ev_kind_e   dec_kind;
  logic [5:0] dec_rc;
  logic       mat_hit;
  // State
  logic [7:0][7:0]   matrix_q, matrix_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [5:0]        fifo_q [RELQ_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q, count_d;
  logic              lshift_q, rshift_q, ctrl_q, graph_q;
  logic              kb_down_q;
  // Apply controls
  logic       mat_press, mat_release, hold_zero, fifo_empty, fifo_full;
  logic       rel_now, push, pop;
  logic [5:0] pop_rc;
  logic [7:0] col_hit;

  // S0: a change of the toggle bit is one event.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      strobe_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_press_q <= 1'b0;
      s1_key_q   <= '0;
    end else begin
      strobe_q   <= kbd.ps2_key[10];
      s1_valid_q <= kbd.ps2_key[10] != strobe_q;
      s1_press_q <= kbd.ps2_key[9];
      s1_key_q   <= kbd.ps2_key[8:0];
    end
  end

  // S1: scancode -> matrix position (octal row/col). E0 12 / E0 59 fall to default and are ignored.
  always_comb begin
    mat_hit = 1'b1;
    dec_rc  = '0;
    case (s1_key_q)
      9'h029: dec_rc = 6'o00;  9'h05A: dec_rc = 6'o01;  9'h066: dec_rc = 6'o02;
      9'h00D: dec_rc = 6'o03;  9'h076: dec_rc = 6'o04;  9'h005: dec_rc = 6'o05;
      9'h006: dec_rc = 6'o06;  9'h004: dec_rc = 6'o07;
      9'h015: dec_rc = 6'o10;  9'h01D: dec_rc = 6'o11;  9'h024: dec_rc = 6'o12;
      9'h02D: dec_rc = 6'o13;  9'h02C: dec_rc = 6'o14;  9'h035: dec_rc = 6'o15;
      9'h03C: dec_rc = 6'o16;  9'h043: dec_rc = 6'o17;
      9'h044: dec_rc = 6'o20;  9'h01C: dec_rc = 6'o21;  9'h01B: dec_rc = 6'o22;
      9'h023: dec_rc = 6'o23;  9'h02B: dec_rc = 6'o24;  9'h034: dec_rc = 6'o25;
      9'h033: dec_rc = 6'o26;  9'h03B: dec_rc = 6'o27;
      9'h042: dec_rc = 6'o30;  9'h04B: dec_rc = 6'o31;  9'h01A: dec_rc = 6'o32;
      9'h022: dec_rc = 6'o33;  9'h021: dec_rc = 6'o34;  9'h02A: dec_rc = 6'o35;
      9'h032: dec_rc = 6'o36;  9'h031: dec_rc = 6'o37;
      9'h03A: dec_rc = 6'o40;  9'h016: dec_rc = 6'o41;  9'h01E: dec_rc = 6'o42;
      9'h026: dec_rc = 6'o43;  9'h025: dec_rc = 6'o44;  9'h02E: dec_rc = 6'o45;
      9'h036: dec_rc = 6'o46;  9'h03D: dec_rc = 6'o47;
      9'h03E: dec_rc = 6'o50;  9'h046: dec_rc = 6'o51;  9'h045: dec_rc = 6'o52;
      9'h04E: dec_rc = 6'o53;  9'h055: dec_rc = 6'o54;  9'h04D: dec_rc = 6'o55;
      9'h054: dec_rc = 6'o56;  9'h05B: dec_rc = 6'o57;
      9'h04C: dec_rc = 6'o60;  9'h052: dec_rc = 6'o61;  9'h041: dec_rc = 6'o62;
      9'h049: dec_rc = 6'o63;  9'h04A: dec_rc = 6'o64;  9'h05D: dec_rc = 6'o65;
      9'h00E: dec_rc = 6'o66;  9'h058: dec_rc = 6'o67;
      9'h16B: dec_rc = 6'o70;  9'h174: dec_rc = 6'o71;  9'h172: dec_rc = 6'o72;
      9'h170: dec_rc = 6'o73;  9'h171: dec_rc = 6'o74;  9'h175: dec_rc = 6'o75;
      9'h16C: dec_rc = 6'o76;  9'h17D: dec_rc = 6'o77;
      default: mat_hit = 1'b0;
    endcase
  end

  always_comb begin
    dec_kind = EvNone;
    case (s1_key_q)
      9'h012:         dec_kind = EvShiftL;
      9'h059:         dec_kind = EvShiftR;
      9'h014, 9'h114: dec_kind = EvCtrl;
      9'h011, 9'h111: dec_kind = EvGraph;
      default:        if (mat_hit) dec_kind = EvMatrix;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_press_q <= 1'b0;
      s2_kind_q  <= EvNone;
      s2_rc_q    <= '0;
    end else begin
      s2_valid_q <= s1_valid_q && (dec_kind != EvNone);
      s2_press_q <= s1_press_q;
      s2_kind_q  <= dec_kind;
      s2_rc_q    <= dec_rc;
    end
  end

  // S2: apply to matrix, hold counter and release FIFO.
  always_comb begin
    mat_press   = s2_valid_q && (s2_kind_q == EvMatrix) && s2_press_q;
    mat_release = s2_valid_q && (s2_kind_q == EvMatrix) && !s2_press_q;
    hold_zero   = hold_cnt_q == '0;
    fifo_empty  = count_q == '0;
    fifo_full   = count_q == DepthVal;
    rel_now     = mat_release && hold_zero && fifo_empty;
    push        = mat_release && !rel_now;
    // A full FIFO is forced to give up its oldest entry so the new release always fits.
    pop         = !fifo_empty && ((push && fifo_full) || (hold_zero && !mat_press));
    pop_rc      = fifo_q[rd_ptr_q];

    matrix_d = matrix_q;
    if (pop)       matrix_d[pop_rc[5:3]][pop_rc[2:0]]   = 1'b0;
    if (mat_press) matrix_d[s2_rc_q[5:3]][s2_rc_q[2:0]] = 1'b1;
    if (rel_now)   matrix_d[s2_rc_q[5:3]][s2_rc_q[2:0]] = 1'b0;

    hold_cnt_d = hold_cnt_q;
    if (mat_press)       hold_cnt_d = HoldLoad;
    else if (!hold_zero) hold_cnt_d = hold_cnt_q - 1'b1;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      matrix_q   <= '0;
      hold_cnt_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      kb_down_q  <= 1'b0;
      for (int i = 0; i < int'(RELQ_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      matrix_q   <= matrix_d;
      hold_cnt_q <= hold_cnt_d;
      count_q    <= count_d;
      kb_down_q  <= |matrix_q;
      if (push) begin
        fifo_q[wr_ptr_q] <= s2_rc_q;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Modifiers bypass the hold mechanism.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      ctrl_q   <= 1'b0;
      graph_q  <= 1'b0;
    end else if (s2_valid_q) begin
      case (s2_kind_q)
        EvShiftL: lshift_q <= s2_press_q;
        EvShiftR: rshift_q <= s2_press_q;
        EvCtrl:   ctrl_q   <= s2_press_q;
        EvGraph:  graph_q  <= s2_press_q;
        default:  ;
      endcase
    end
  end

  // Column readback: any selected (low) row with the key down pulls its column low.
  always_comb begin
    col_hit = '0;
    for (int r = 0; r < 8; r++) col_hit = col_hit | (matrix_q[r] & {8{~kbd.kb_row[r]}});
  end

  assign kbd.kb_col   = ~col_hit;
  assign kbd.kb_shift = ~(lshift_q | rshift_q);
  assign kbd.kb_ctrl  = ~ctrl_q;
  assign kbd.kb_graph = ~graph_q;
  assign kbd.kb_down  = kb_down_q;

endmodule

// File: tb/tb_einstein_kbd_matrix.sv
// Self-checking bench for einstein_kbd_matrix: decode table vectors plus hand-written
// sequences for hold stretching, FIFO overflow/drain, dual shift and mid-hold reset.
module tb_einstein_kbd_matrix;
  localparam int unsigned M = 40;

  logic clk_sys = 1'b0;
  logic reset;
  logic strobe;
  int   checks = 0;
  int   errors = 0;

  einstein_kbd_matrix_if kbd ();

  einstein_kbd_matrix #(
    .MIN_HOLD   (M),
    .HOLD_W     (8),
    .RELQ_DEPTH (4)
  ) u_dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .kbd     (kbd)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic [7:0] row;
    logic [7:0] col;
    logic       shift;
    logic       ctrl;
    logic       graph;
    logic       down;
  } vec_t;

  vec_t vecs [16];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Toggle one event; returns 1 time unit after the edge that accepts it.
  task automatic send(input logic press, input logic ext, input logic [7:0] code);
    @(negedge clk_sys);
    strobe = ~strobe;
    kbd.ps2_key = {strobe, press, ext, code};
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk8({name, " col"}, kbd.kb_col, 8'hFF);
    chk1({name, " shift"}, kbd.kb_shift, 1'b1);
    chk1({name, " ctrl"}, kbd.kb_ctrl, 1'b1);
    chk1({name, " graph"}, kbd.kb_graph, 1'b1);
  endtask

  initial begin
    //          ext   code   row    col    sh ct gr dn
    vecs[0]  = '{1'b0, 8'h29, 8'hFE, 8'hFE, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 8'h1C, 8'hFB, 8'hFD, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 8'h75, 8'h7F, 8'hDF, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 8'h1C, 8'h00, 8'hFD, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 8'h1C, 8'hFE, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h29, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 8'h12, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h59, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h14, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'h14, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h11, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h11, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h12, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 8'h59, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'h24, 8'hFD, 8'hFB, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset
    strobe      = 1'b0;
    reset       = 1'b1;
    kbd.ps2_key = '0;
    kbd.kb_row  = 8'h00;
    tick(2);
    chk_idle("reset");
    chk1("reset down", kbd.kb_down, 1'b0);
    reset = 1'b0;
    tick(2);

    // Decode table: press, check at +1/+2/+3, let the hold expire, release, check idle.
    for (int i = 0; i < 16; i++) begin
      kbd.kb_row = vecs[i].row;
      send(1'b1, vecs[i].ext, vecs[i].code);
      tick(1);
      chk_idle($sformatf("vec%0d +1", i));
      tick(1);
      chk8($sformatf("vec%0d col", i), kbd.kb_col, vecs[i].col);
      chk1($sformatf("vec%0d shift", i), kbd.kb_shift, vecs[i].shift);
      chk1($sformatf("vec%0d ctrl", i), kbd.kb_ctrl, vecs[i].ctrl);
      chk1($sformatf("vec%0d graph", i), kbd.kb_graph, vecs[i].graph);
      tick(1);
      chk1($sformatf("vec%0d down", i), kbd.kb_down, vecs[i].down);
      tick(M);
      send(1'b0, vecs[i].ext, vecs[i].code);
      tick(2);
      chk_idle($sformatf("vec%0d rel", i));
      tick(1);
      chk1($sformatf("vec%0d rel down", i), kbd.kb_down, 1'b0);
    end

    // Short tap is stretched by the hold (press toggle edge = T0).
    kbd.kb_row = 8'hFE;
    send(1'b1, 1'b0, 8'h29);
    chk8("tap T0", kbd.kb_col, 8'hFF);
    tick(1);
    chk8("tap T0+1", kbd.kb_col, 8'hFF);
    tick(1);
    chk8("tap T0+2", kbd.kb_col, 8'hFE);
    chk1("tap down T0+2", kbd.kb_down, 1'b0);
    tick(1);
    chk1("tap down T0+3", kbd.kb_down, 1'b1);
    send(1'b0, 1'b0, 8'h29);
    tick(M - 2);
    chk8("tap held", kbd.kb_col, 8'hFE);
    tick(1);
    chk8("tap cleared", kbd.kb_col, 8'hFF);
    chk1("tap down still", kbd.kb_down, 1'b1);
    tick(1);
    chk1("tap down fell", kbd.kb_down, 1'b0);

    // Long press then release clears immediately.
    kbd.kb_row = 8'hFB;
    send(1'b1, 1'b0, 8'h1C);
    tick(M + 5);
    chk8("long held", kbd.kb_col, 8'hFD);
    send(1'b0, 1'b0, 8'h1C);
    tick(1);
    chk8("long rel +1", kbd.kb_col, 8'hFD);
    tick(1);
    chk8("long rel +2", kbd.kb_col, 8'hFF);

    // Two shift sources.
    kbd.kb_row = 8'h00;
    send(1'b1, 1'b0, 8'h12);
    tick(2);
    chk1("lshift", kbd.kb_shift, 1'b0);
    send(1'b1, 1'b0, 8'h59);
    send(1'b0, 1'b0, 8'h12);
    tick(3);
    chk1("rshift only", kbd.kb_shift, 1'b0);
    send(1'b0, 1'b0, 8'h59);
    tick(1);
    chk1("shift rel +1", kbd.kb_shift, 1'b0);
    tick(1);
    chk1("shift rel +2", kbd.kb_shift, 1'b1);
    tick(M);

    // FIFO overflow: five taps in distinct columns 0..4.
    send(1'b1, 1'b0, 8'h29);
    send(1'b0, 1'b0, 8'h29);
    send(1'b1, 1'b0, 8'h1C);
    send(1'b0, 1'b0, 8'h1C);
    send(1'b1, 1'b0, 8'h24);
    send(1'b0, 1'b0, 8'h24);
    send(1'b1, 1'b0, 8'h26);
    send(1'b0, 1'b0, 8'h26);
    send(1'b1, 1'b0, 8'h25);
    send(1'b0, 1'b0, 8'h25);
    tick(1);
    chk8("ovf all", kbd.kb_col, 8'hE0);
    tick(1);
    chk8("ovf oldest", kbd.kb_col, 8'hE1);
    tick(M - 1);
    chk8("ovf hold", kbd.kb_col, 8'hE1);
    tick(1);
    chk8("drain 1", kbd.kb_col, 8'hE3);
    tick(1);
    chk8("drain 2", kbd.kb_col, 8'hE7);
    tick(1);
    chk8("drain 3", kbd.kb_col, 8'hEF);
    tick(1);
    chk8("drain 4", kbd.kb_col, 8'hFF);
    chk1("drain down", kbd.kb_down, 1'b1);
    tick(1);
    chk1("drain down fell", kbd.kb_down, 1'b0);

    // Extended key and ignored codes.
    kbd.kb_row = 8'h7F;
    send(1'b1, 1'b1, 8'h75);
    tick(2);
    chk8("up key", kbd.kb_col, 8'hDF);
    send(1'b1, 1'b1, 8'h12);
    send(1'b1, 1'b0, 8'h00);
    send(1'b1, 1'b1, 8'h59);
    tick(3);
    chk8("ignored col", kbd.kb_col, 8'hDF);
    chk1("ignored shift", kbd.kb_shift, 1'b1);
    chk1("ignored down", kbd.kb_down, 1'b1);

    // Reset mid-hold with FIFO non-empty and an event in flight.
    kbd.kb_row = 8'h00;
    send(1'b1, 1'b0, 8'h1C);
    send(1'b0, 1'b0, 8'h1C);
    send(1'b1, 1'b0, 8'h12);
    tick(3);
    chk8("pre-reset col", kbd.kb_col, 8'hDD);
    chk1("pre-reset shift", kbd.kb_shift, 1'b0);
    send(1'b1, 1'b0, 8'h29);
    reset       = 1'b1;
    kbd.ps2_key = '0;
    strobe      = 1'b0;
    #1;
    chk_idle("async reset");
    chk1("async reset down", kbd.kb_down, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(3);
    chk8("after reset", kbd.kb_col, 8'hFF);
    chk1("after reset down", kbd.kb_down, 1'b0);
    send(1'b1, 1'b0, 8'h29);
    tick(2);
    chk8("post-reset key", kbd.kb_col, 8'hFE);
    tick(1);
    chk1("post-reset down", kbd.kb_down, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
